sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 133 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-master round-robin front end for a single-port synchronous SRAM, with
// optional zero-fill after reset, out-of-range trapping and one-cycle read return.
`default_nettype none

module sram_port_arbiter #(
    parameter int ADDR_W         = 14,
    parameter int DEPTH          = 10240,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] sram_address,
    output logic [3:0]        sram_byteenable,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic [31:0]       sram_writedata,
    output logic              sram_clken,
    input  logic [31:0]       sram_readdata,
    output logic              init_done,
    output logic [1:0]        range_err,
    input  logic              err_clr
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              ptr_q, ptr_d;
    logic              init_done_q;
    logic [1:0]        rvld_q, rvld_d;
    logic [1:0]        roor_q, roor_d;
    logic [1:0]        range_err_q, range_err_d;

    logic              run, req0, req1, gnt0, gnt1, gnt_wr, gnt_in_rng;
    logic [ADDR_W-1:0] gnt_addr;

    always_comb begin
        run        = (state_q == S_RUN);
        req0       = m0_read | m0_write;
        req1       = m1_read | m1_write;
        gnt0       = run && req0 && (!req1 || !ptr_q);
        gnt1       = run && req1 && (!req0 || ptr_q);
        gnt_addr   = gnt1 ? m1_address : m0_address;
        gnt_wr     = gnt1 ? m1_write : m0_write;
        gnt_in_rng = ({1'b0, gnt_addr} < DEPTH_L);

        ptr_d       = (gnt0 || gnt1) ? gnt0 : ptr_q;
        rvld_d      = {gnt1 && m1_read && !m1_write, gnt0 && m0_read && !m0_write};
        roor_d      = {2{!gnt_in_rng}};
        range_err_d = (err_clr ? 2'b00 : range_err_q)
                    | {gnt1 && !gnt_in_rng, gnt0 && !gnt_in_rng};

        sram_address    = gnt_addr;
        sram_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
        sram_writedata  = gnt1 ? m1_writedata : m0_writedata;
        sram_chipselect = 1'b0;
        sram_write      = 1'b0;
        if (!run) begin
            sram_address    = clr_cnt_q;
            sram_byteenable = 4'hF;
            sram_writedata  = 32'h0;
            sram_chipselect = 1'b1;
            sram_write      = 1'b1;
        end else if (gnt0 || gnt1) begin
            sram_chipselect = gnt_in_rng;
            sram_write      = gnt_wr && gnt_in_rng;
        end
        // The FSM sits in CLEAR during reset; keep the SRAM idle until release.
        if (reset) begin
            sram_chipselect = 1'b0;
            sram_write      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            clr_cnt_q   <= '0;
            ptr_q       <= 1'b0;
            init_done_q <= 1'b0;
            rvld_q      <= 2'b00;
            roor_q      <= 2'b00;
            range_err_q <= 2'b00;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if ({1'b0, clr_cnt_q} == CLR_LAST) begin
                        state_q     <= S_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: init_done_q <= 1'b1;
            endcase
            ptr_q       <= ptr_d;
            rvld_q      <= rvld_d;
            roor_q      <= roor_d;
            range_err_q <= range_err_d;
        end
    end

    assign m0_waitrequest   = !run || (req0 && !gnt0);
    assign m1_waitrequest   = !run || (req1 && !gnt1);
    assign m0_readdatavalid = rvld_q[0];
    assign m1_readdatavalid = rvld_q[1];
    assign m0_readdata      = (rvld_q[0] && !roor_q[0]) ? sram_readdata : 32'h0;
    assign m1_readdata      = (rvld_q[1] && !roor_q[1]) ? sram_readdata : 32'h0;
    assign sram_clken       = 1'b1;
    assign init_done        = init_done_q;
    assign range_err        = range_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (DEPTH=16) with a behavioural SRAM model.
`timescale 1ns/1ps

module tb_sram_port_arbiter;

    localparam int AW = 14;

    logic          clk, reset, err_clr;
    logic [AW-1:0] m0_address, m1_address;
    logic [3:0]    m0_byteenable, m1_byteenable;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [31:0]   m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [31:0]   m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] sram_address;
    logic [3:0]    sram_byteenable;
    logic          sram_chipselect, sram_write, sram_clken;
    logic [31:0]   sram_writedata, sram_readdata;
    logic          init_done;
    logic [1:0]    range_err;

    int tests = 0;
    int fails = 0;

    sram_port_arbiter #(.ADDR_W(AW), .DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .sram_address(sram_address), .sram_byteenable(sram_byteenable),
        .sram_chipselect(sram_chipselect), .sram_write(sram_write),
        .sram_writedata(sram_writedata), .sram_clken(sram_clken),
        .sram_readdata(sram_readdata), .init_done(init_done), .range_err(range_err),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: registered address, unregistered data, byte-masked writes.
    logic [31:0] mem [0:15];
    logic [3:0]  raddr_q = 4'd0;
    initial for (int i = 0; i < 16; i++) mem[i] = 32'hDEADBEEF;
    always @(posedge clk) begin
        if (sram_chipselect && sram_address < 14'd16) begin
            if (sram_write)
                mem[sram_address[3:0]] <= {
                    sram_byteenable[3] ? sram_writedata[31:24] : mem[sram_address[3:0]][31:24],
                    sram_byteenable[2] ? sram_writedata[23:16] : mem[sram_address[3:0]][23:16],
                    sram_byteenable[1] ? sram_writedata[15:8]  : mem[sram_address[3:0]][15:8],
                    sram_byteenable[0] ? sram_writedata[7:0]   : mem[sram_address[3:0]][7:0]};
            else
                raddr_q <= sram_address[3:0];
        end
    end
    assign sram_readdata = mem[raddr_q];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] seq_a [4];
    logic [31:0]   seq_d [4];

    initial begin
        seq_a = '{14'd0, 14'd2, 14'd3, 14'd1};
        seq_d = '{32'h0, 32'h22222222, 32'h0, 32'h11111111};
        reset = 1'b1; err_clr = 1'b0;
        m0_address = 14'd5; m0_byteenable = 4'b0011; m0_read = 1'b0; m0_write = 1'b1;
        m0_writedata = 32'hA5A5A5A5;
        m1_address = 14'd5; m1_byteenable = 4'hF; m1_read = 1'b1; m1_write = 1'b0;
        m1_writedata = 32'h0;

        tick(); tick(); #1;
        chk("rst_cs", 32'(sram_chipselect), 32'd0);
        chk("rst_wr", 32'(sram_write), 32'd0);
        chk("rst_init", 32'(init_done), 32'd0);
        chk("rst_err", 32'(range_err), 32'd0);
        chk("rst_wait0", 32'(m0_waitrequest), 32'd1);
        chk("rst_clken", 32'(sram_clken), 32'd1);
        reset = 1'b0;
        #1;
        // Zero-fill: one write per cycle with both masters stalled
        for (int k = 0; k < 16; k++) begin
            chk("clr_addr", 32'(sram_address), 32'(k));
            chk("clr_cs_wr", {30'd0, sram_chipselect, sram_write}, 32'd3);
            chk("clr_be_wd", {28'd0, sram_byteenable} | sram_writedata, 32'hF);
            chk("clr_init", 32'(init_done), 32'd0);
            chk("clr_wait", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd3);
            tick(); #1;
        end
        chk("init_done", 32'(init_done), 32'd1);
        chk("mem0_zero", mem[0], 32'h0);
        chk("mem15_zero", mem[15], 32'h0);
        // m0 write (pointer 0) beats m1 read
        chk("w5_wait", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd1);
        chk("w5_cs_wr", {30'd0, sram_chipselect, sram_write}, 32'd3);
        chk("w5_addr", 32'(sram_address), 32'd5);
        chk("w5_be", 32'(sram_byteenable), 32'h3);
        chk("w5_wd", sram_writedata, 32'hA5A5A5A5);
        tick(); m0_write = 1'b0; #1;
        chk("r5_wait1", 32'(m1_waitrequest), 32'd0);
        chk("r5_cs_wr", {30'd0, sram_chipselect, sram_write}, 32'd2);
        chk("r5_rdv_early", 32'(m1_readdatavalid), 32'd0);
        tick(); m1_read = 1'b0; #1;
        chk("r5_rdv", 32'(m1_readdatavalid), 32'd1);
        chk("r5_data", m1_readdata, 32'h0000A5A5);
        chk("r5_m0_rdv", 32'(m0_readdatavalid), 32'd0);

        tick(); m0_write = 1'b1; m0_address = 14'd1; m0_byteenable = 4'hF;
        m0_writedata = 32'h11111111; #1;
        chk("w1_wait", 32'(m0_waitrequest), 32'd0);
        chk("w1_cs", 32'(sram_chipselect), 32'd1);
        chk("idle_rdata", m1_readdata, 32'h0);
        tick(); m0_write = 1'b0; m1_write = 1'b1; m1_address = 14'd2;
        m1_writedata = 32'h22222222; #1;
        chk("w2_wait", 32'(m1_waitrequest), 32'd0);
        // Both reading continuously: alternate m0,m1,m0,m1
        tick(); m1_write = 1'b0; m0_read = 1'b1; m0_address = 14'd1;
        m1_read = 1'b1; m1_address = 14'd2; #1;
        chk("rrA_wait", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd1);
        chk("rrA_addr", 32'(sram_address), 32'd1);
        tick(); #1;
        chk("rrB_wait", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd2);
        chk("rrB_addr", 32'(sram_address), 32'd2);
        chk("rrB_rdv", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd2);
        chk("rrB_data", m0_readdata, 32'h11111111);
        tick(); #1;
        chk("rrC_wait", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd1);
        chk("rrC_rdv", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd1);
        chk("rrC_data", m1_readdata, 32'h22222222);
        tick(); #1;
        chk("rrD_wait", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd2);
        chk("rrD_data", m0_readdata, 32'h11111111);
        tick(); m0_read = 1'b0; m1_read = 1'b0; #1;
        chk("rrE_data", m1_readdata, 32'h22222222);
        chk("idle_cs_wr", {30'd0, sram_chipselect, sram_write}, 32'd0);
        chk("idle_wait", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd0);
        chk("idle_m0rdv", 32'(m0_readdatavalid), 32'd0);
        // m1 alone for four cycles
        for (int i = 0; i < 4; i++) begin
            tick(); m1_read = 1'b1; m1_address = seq_a[i]; #1;
            chk("solo_wait", 32'(m1_waitrequest), 32'd0);
            chk("solo_cs", 32'(sram_chipselect), 32'd1);
            chk("solo_addr", 32'(sram_address), 32'(seq_a[i]));
            if (i > 0) begin
                chk("solo_rdv", 32'(m1_readdatavalid), 32'd1);
                chk("solo_data", m1_readdata, seq_d[i-1]);
            end
        end
        tick(); m1_read = 1'b0; #1;
        chk("solo_rdv_last", 32'(m1_readdatavalid), 32'd1);
        chk("solo_data_last", m1_readdata, seq_d[3]);
        // Out-of-range accesses
        tick(); m1_write = 1'b1; m1_address = 14'd16; m1_writedata = 32'hFFFFFFFF; #1;
        chk("oor_w_wait", 32'(m1_waitrequest), 32'd0);
        chk("oor_w_cs_wr", {30'd0, sram_chipselect, sram_write}, 32'd0);
        chk("oor_err_pre", 32'(range_err), 32'd0);
        tick(); m1_write = 1'b0; m1_read = 1'b1; m1_address = 14'd10240; #1;
        chk("oor_err", 32'(range_err), 32'h2);
        chk("oor_r_cs", 32'(sram_chipselect), 32'd0);
        chk("oor_r_wait", 32'(m1_waitrequest), 32'd0);
        tick(); m1_read = 1'b0; #1;
        chk("oor_r_rdv", 32'(m1_readdatavalid), 32'd1);
        chk("oor_r_data", m1_readdata, 32'h0);
        chk("oor_w_drop", mem[0], 32'h0);
        tick(); m0_write = 1'b1; m0_address = 14'd20; err_clr = 1'b1; #1;
        tick(); m0_write = 1'b0; err_clr = 1'b0; #1;
        chk("err_set_wins", 32'(range_err), 32'h1);
        tick(); err_clr = 1'b1; #1;
        tick(); err_clr = 1'b0; #1;
        chk("err_clr", 32'(range_err), 32'h0);
        // Reset with a read in flight
        tick(); m0_read = 1'b1; m0_address = 14'd2; #1;
        chk("pre_rst_wait", 32'(m0_waitrequest), 32'd0);
        chk("pre_rst_cs", 32'(sram_chipselect), 32'd1);
        tick(); m0_read = 1'b0; reset = 1'b1; #1;
        chk("inflt_rdv", 32'(m0_readdatavalid), 32'd0);
        chk("inflt_data", m0_readdata, 32'h0);
        chk("inflt_cs_wr", {30'd0, sram_chipselect, sram_write}, 32'd0);
        chk("inflt_init", 32'(init_done), 32'd0);
        tick(); reset = 1'b0; #1;
        chk("post_rdv", 32'(m0_readdatavalid), 32'd0);
        chk("post_clr_addr", 32'(sram_address), 32'd0);
        chk("post_clr_cs", 32'(sram_chipselect), 32'd1);
        chk("post_wait", 32'(m0_waitrequest), 32'd1);
        tick(); #1;
        chk("post_rdv2", 32'(m0_readdatavalid), 32'd0);
        chk("post_clr_addr2", 32'(sram_address), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
